// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared widths, FSM state type and requantization helper
package npu_pkg;

  localparam int PSUM_W = 18;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } psum_state_t;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } pix_t;

  // ReLU, round-half-up arithmetic right shift, then clamp to the unsigned
  // pixel range. Two guard bits keep the rounding add from overflowing.
  function automatic pix_t requant(input logic signed [ACC_W-1:0] s,
                                   input logic [3:0]              shift,
                                   input logic                    relu);
    logic signed [ACC_W+1:0] x;
    logic signed [ACC_W+1:0] half;
    logic signed [ACC_W+1:0] r;
    pix_t                    p;
    x = {{2{s[ACC_W-1]}}, s};
    if (relu && s[ACC_W-1]) begin
      x = '0;
    end
    half = '0;
    if (shift != 4'd0) begin
      half[shift - 4'd1] = 1'b1;
    end
    r = (x + half) >>> shift;
    if (r[ACC_W+1]) begin
      p.data = '0;
      p.sat  = 1'b1;
    end else if (r[ACC_W:OUT_W] != '0) begin
      p.data = '1;
      p.sat  = 1'b1;
    end else begin
      p.data = r[OUT_W-1:0];
      p.sat  = 1'b0;
    end
    return p;
  endfunction

endpackage

// File: rtl/out_fifo.sv
// rtl/out_fifo.sv - count-based synchronous FIFO with async active-low reset
module out_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue is only legal when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_requant.sv
// rtl/psum_requant.sv - partial-sum accumulator with ReLU/requant and output queue
module psum_requant #(
  parameter int PSUM_W    = npu_pkg::PSUM_W,
  parameter int ACC_W     = npu_pkg::ACC_W,
  parameter int OUT_W     = npu_pkg::OUT_W,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cfg_shift,
  input  logic              cfg_relu,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [PSUM_W-1:0] psum_data,
  input  logic              psum_first,
  input  logic              psum_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              err_ovf,
  output logic              err_proto
);

  import npu_pkg::*;

  psum_state_t              state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [3:0]               shift_q, shift_d;
  logic                     relu_q, relu_d;
  logic signed [ACC_W:0]    sum_w;
  logic                     beat;
  logic                     pop;
  logic                     push;
  logic                     ovf_set;
  logic                     proto_set;
  logic                     full;
  logic                     empty;
  pix_t                     pix;
  logic [OUT_W:0]           head;

  assign pop        = out_valid && out_ready;
  assign psum_ready = rst && (!full || pop);
  assign beat       = psum_valid && psum_ready;
  assign out_valid  = !empty;
  assign out_sat    = head[OUT_W];
  assign out_data   = head[OUT_W-1:0];

  // One guard bit makes the add exact so overflow can be detected and clamped.
  assign sum_w = {acc_q[ACC_W-1], acc_q}
               + {{(ACC_W + 1 - PSUM_W){psum_data[PSUM_W-1]}}, psum_data};

  // Next-state, accumulator update, cfg capture and error detection.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    push      = 1'b0;
    ovf_set   = 1'b0;
    proto_set = 1'b0;
    if (beat) begin
      // A missing first in IDLE or a stray first in ACCUM both restart a group.
      if ((state_q == IDLE) != psum_first) begin
        proto_set = 1'b1;
      end
      if (psum_first || state_q == IDLE) begin
        acc_d   = {{(ACC_W - PSUM_W){psum_data[PSUM_W-1]}}, psum_data};
        shift_d = cfg_shift;
        relu_d  = cfg_relu;
      end else if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
        ovf_set = 1'b1;
        acc_d   = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_d = sum_w[ACC_W-1:0];
      end
      if (psum_last) begin
        push    = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = ACCUM;
      end
    end
  end

  // The value pushed uses this beat's final sum and the group's effective cfg.
  assign pix = requant(acc_d, shift_d, relu_d);

  // State, accumulator, latched cfg and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      err_ovf   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      err_ovf   <= err_ovf | ovf_set;
      err_proto <= err_proto | proto_set;
    end
  end

  out_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pix.sat, pix.data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_psum_requant.sv
// tb/tb_psum_requant.sv - randomized and directed self-checking bench for psum_requant
module tb_psum_requant;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  cfg_shift;
  logic        cfg_relu;
  logic        psum_valid;
  logic        psum_ready;
  logic [17:0] psum_data;
  logic        psum_first;
  logic        psum_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        err_ovf;
  logic        err_proto;

  psum_requant #(.OUT_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_data  (psum_data),
    .psum_first (psum_first),
    .psum_last  (psum_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .err_ovf    (err_ovf),
    .err_proto  (err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: expected queue entries encoded as sat*256 + data.
  int     q[$];
  int     dut_pops[$];
  bit     m_open;
  longint m_acc;
  int     m_shift;
  bit     m_relu;
  bit     m_ovf;
  bit     m_proto;
  bit     last_ready;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int m_requant(input longint s, input int sh, input bit rl);
    longint r;
    if (rl && s < 0) s = 0;
    r = (sh > 0) ? ((s + (longint'(1) <<< (sh - 1))) >>> sh) : s;
    if (r < 0)   return 256;
    if (r > 255) return 256 + 255;
    return int'(r);
  endfunction

  task automatic model_reset();
    q.delete();
    m_open  = 0;
    m_acc   = 0;
    m_ovf   = 0;
    m_proto = 0;
  endtask

  task automatic model_beat(input longint val, input bit f, input bit l,
                            input int sh, input bit rl);
    if (f != !m_open) m_proto = 1;
    if (f || !m_open) begin
      m_acc   = val;
      m_shift = sh;
      m_relu  = rl;
    end else begin
      m_acc = m_acc + val;
      if (m_acc > 8388607)  begin m_acc = 8388607;  m_ovf = 1; end
      if (m_acc < -8388608) begin m_acc = -8388608; m_ovf = 1; end
    end
    if (l) begin
      q.push_back(m_requant(m_acc, m_shift, m_relu));
      m_open = 0;
    end else begin
      m_open = 1;
    end
  endtask

  // One clock cycle, entered and left at a falling edge: check registered
  // outputs, drive inputs, check the combinational ready, advance the model.
  task automatic step(input bit v, input int d, input bit f, input bit l,
                      input int sh, input bit rl, input bit ordy,
                      output bit accepted);
    bit exp_rdy;
    bit pop;
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0] % 256);
      chk("out_sat", out_sat, q[0] / 256);
    end
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_proto", err_proto, m_proto);
    psum_valid = v;
    psum_data  = d[17:0];
    psum_first = f;
    psum_last  = l;
    cfg_shift  = sh[3:0];
    cfg_relu   = rl;
    out_ready  = ordy;
    #1;
    exp_rdy    = rst && (q.size() < DEPTH || (q.size() > 0 && ordy));
    last_ready = psum_ready;
    chk("psum_ready", psum_ready, exp_rdy);
    pop = (q.size() > 0) && ordy;
    if (pop) begin
      dut_pops.push_back(int'(out_data));
      void'(q.pop_front());
    end
    accepted = v && exp_rdy;
    if (accepted) model_beat(longint'($signed(psum_data)), f, l, sh, rl);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, ordy, a);
  endtask

  task automatic send(input int d, input bit f, input bit l, input int sh,
                      input bit rl, input bit ordy);
    bit a;
    int tries;
    tries = 0;
    do begin
      step(1, d, f, l, sh, rl, ordy, a);
      tries++;
    end while (!a && tries < 20);
    if (!a) begin
      n_checks++;
      $display("FAIL send_timeout: got stalled expected accept within 20 cycles");
    end
  endtask

  initial begin
    bit a;
    rst = 1'b0;
    psum_valid = 0; psum_data = '0; psum_first = 0; psum_last = 0;
    cfg_shift = '0; cfg_relu = 0; out_ready = 0;
    model_reset();
    @(negedge clk);
    idle(2, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_psum_ready", last_ready, 0);
    rst = 1'b1;

    // Single beat first+last: 1000, shift 2, relu -> 250.
    send(1000, 1, 1, 2, 1, 0);
    chk("lat_valid", out_valid, 1);
    chk("t1_data", out_data, 250);
    chk("t1_sat", out_sat, 0);
    idle(1, 1);

    // Group {300,-100,57}, shift 1 latched on first beat -> 129.
    send(300, 1, 0, 1, 0, 1);
    send(-100, 0, 0, 7, 1, 1);
    send(57, 0, 1, 7, 1, 1);
    chk("t2_data", out_data, 129);
    chk("t2_sat", out_sat, 0);
    idle(1, 1);

    // Negative single beats with and without ReLU.
    send(-500, 1, 1, 0, 1, 0);
    chk("t3_relu_data", out_data, 0);
    chk("t3_relu_sat", out_sat, 0);
    idle(1, 1);
    send(-500, 1, 1, 0, 0, 0);
    chk("t3_norelu_data", out_data, 0);
    chk("t3_norelu_sat", out_sat, 1);
    idle(1, 1);

    // 65 beats of max positive: accumulator saturates.
    send(131071, 1, 0, 0, 0, 1);
    for (int i = 0; i < 63; i++) send(131071, 0, 0, 0, 0, 1);
    send(131071, 0, 1, 0, 0, 1);
    chk("t4_ovf", err_ovf, 1);
    chk("t4_data", out_data, 255);
    chk("t4_sat", out_sat, 1);
    idle(1, 1);

    // Backpressure: two queued, third stalls, then drain in order.
    dut_pops.delete();
    send(10, 1, 1, 0, 0, 0);
    send(20, 1, 1, 0, 0, 0);
    step(1, 30, 1, 1, 0, 0, 0, a);
    chk("bp_stall_ready", last_ready, 0);
    chk("bp_stall_acc", a, 0);
    send(30, 1, 1, 0, 0, 1);
    idle(4, 1);
    chk("bp_pop_count", dut_pops.size(), 3);
    if (dut_pops.size() == 3) begin
      chk("bp_pop0", dut_pops[0], 10);
      chk("bp_pop1", dut_pops[1], 20);
      chk("bp_pop2", dut_pops[2], 30);
    end

    // Reset mid-group with a queued result, then a beat without first.
    send(99, 1, 1, 0, 0, 0);
    send(5, 1, 0, 0, 0, 0);
    send(7, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    idle(2, 1);
    chk("rm_out_valid", out_valid, 0);
    chk("rm_err_ovf", err_ovf, 0);
    chk("rm_err_proto", err_proto, 0);
    rst = 1'b1;
    send(9, 0, 1, 0, 0, 0);
    chk("rm_proto_set", err_proto, 1);
    chk("rm_data", out_data, 9);
    idle(1, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = int'($urandom_range(0, 262143)) - 131072;
      if ($urandom % 4 == 0) d = int'($urandom_range(0, 2000)) - 1000;
      step($urandom % 4 != 0, d, $urandom % 5 == 0, $urandom % 4 == 0,
           int'($urandom_range(0, 15)), $urandom % 2 == 1, $urandom % 3 != 0, a);
    end
    idle(4, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
